// File: rtl/fs01_timing_gen.sv
// rtl/fs01_timing_gen.sv - FS01 base scaler stage divider with edge pulses, resync and stall alarm
// Feeds the A1 scaler: divides CLOCK by DIV into FS01/FS01_ and flags both FS01 edges.
module fs01_timing_gen #(
  parameter int DIV       = 20,
  parameter int STALL_LIM = 64,
  parameter int CNT_W     = 5
) (
  input  logic             CLOCK,
  input  logic             rst_,
  input  logic             STOP,
  input  logic             SYNC_,
  input  logic             CLRAL,
  output logic             FS01,
  output logic             FS01_,
  output logic             F01A,
  output logic             F01B,
  output logic             SCAFAL,
  output logic [CNT_W-1:0] CNT
);

  localparam int SW = $clog2(STALL_LIM + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(DIV / 2 - 1);
  localparam logic [SW-1:0]    LIM      = SW'(STALL_LIM);
  localparam logic [SW-1:0]    LIM_M1   = SW'(STALL_LIM - 1);

  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    stall;
  logic             f01a_q;
  logic             f01b_q;
  logic             scafal_q;

  // FS01 is a pure decode of the phase register so it carries no extra latency.
  assign FS01   = (cnt >= HALF);
  assign FS01_  = ~FS01;
  assign F01A   = f01a_q;
  assign F01B   = f01b_q;
  assign SCAFAL = scafal_q;
  assign CNT    = cnt;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      cnt    <= '0;
      f01a_q <= 1'b0;
      f01b_q <= 1'b0;
    end else if (!SYNC_) begin
      cnt    <= '0;
      f01a_q <= 1'b0;
      f01b_q <= 1'b0;
    end else if (STOP) begin
      f01a_q <= 1'b0;
      f01b_q <= 1'b0;
    end else begin
      f01b_q <= (cnt == HALF_M1);
      if (cnt == LAST) begin
        cnt    <= '0;
        f01a_q <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        f01a_q <= 1'b0;
      end
    end
  end

  // Stall detector is independent of SYNC_; only STOP drives it.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      stall    <= '0;
      scafal_q <= 1'b0;
    end else begin
      if (!STOP)
        stall <= '0;
      else if (stall != LIM)
        stall <= stall + 1'b1;

      if (STOP && (stall == LIM_M1))
        scafal_q <= 1'b1;
      else if (CLRAL)
        scafal_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fs01_timing_gen.sv
// tb/tb_fs01_timing_gen.sv - directed self-checking bench for fs01_timing_gen
module tb_fs01_timing_gen;

  logic       CLOCK = 1'b0;
  logic       rst_  = 1'b0;
  logic       STOP  = 1'b0;
  logic       SYNC_ = 1'b1;
  logic       CLRAL = 1'b0;
  logic       FS01, FS01_, F01A, F01B, SCAFAL;
  logic [4:0] CNT;

  int n_cmp = 0;
  int n_bad = 0;

  fs01_timing_gen #(.DIV(20), .STALL_LIM(64), .CNT_W(5)) dut (
    .CLOCK(CLOCK), .rst_(rst_), .STOP(STOP), .SYNC_(SYNC_), .CLRAL(CLRAL),
    .FS01(FS01), .FS01_(FS01_), .F01A(F01A), .F01B(F01B), .SCAFAL(SCAFAL), .CNT(CNT)
  );

  always #5 CLOCK = ~CLOCK;

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic step;
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  // Packs {CNT, FS01, FS01_, F01A, F01B} for DIV=20.
  function automatic logic [8:0] obs;
    return {CNT, FS01, FS01_, F01A, F01B};
  endfunction

  function automatic logic [8:0] expv(input int c, input bit a, input bit b);
    logic [4:0] cc;
    cc = 5'(c);
    return {cc, (c >= 10), (c < 10), a, b};
  endfunction

  task automatic test_reset;
    #3;
    n_cmp++;
    if (obs() !== expv(0, 0, 0) || SCAFAL !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %h scafal %b, want %h scafal 0", obs(), SCAFAL, expv(0, 0, 0));
    end
    @(negedge CLOCK);
    @(negedge CLOCK);
    rst_ = 1'b1;
  endtask

  task automatic test_free_run;
    for (int k = 1; k <= 60; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv(k % 20, (k % 20) == 0, (k % 20) == 10)) begin
        n_bad++;
        $display("FAIL free_run edge %0d: got %h, want %h", k, obs(), expv(k % 20, (k % 20) == 0, (k % 20) == 10));
      end
    end
  endtask

  task automatic test_stop_low;
    for (int k = 0; k < 7; k++) step();
    STOP = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv(7, 0, 0)) begin
        n_bad++;
        $display("FAIL stop_low hold %0d: got %h, want %h", k, obs(), expv(7, 0, 0));
      end
    end
    STOP = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv(7 + k, 0, k == 3)) begin
        n_bad++;
        $display("FAIL stop_low resume %0d: got %h, want %h", k, obs(), expv(7 + k, 0, k == 3));
      end
    end
  endtask

  task automatic test_stop_high;
    STOP = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv(15, 0, 0)) begin
        n_bad++;
        $display("FAIL stop_high hold %0d: got %h, want %h", k, obs(), expv(15, 0, 0));
      end
    end
    STOP = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv((15 + k) % 20, k == 5, 0)) begin
        n_bad++;
        $display("FAIL stop_high resume %0d: got %h, want %h", k, obs(), expv((15 + k) % 20, k == 5, 0));
      end
    end
    for (int k = 0; k < 15; k++) step();
  endtask

  task automatic test_sync(input bit with_stop);
    SYNC_ = 1'b0;
    STOP  = with_stop;
    step();
    n_cmp++;
    if (obs() !== expv(0, 0, 0)) begin
      n_bad++;
      $display("FAIL sync stop=%0d forced: got %h, want %h", with_stop, obs(), expv(0, 0, 0));
    end
    SYNC_ = 1'b1;
    STOP  = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_cmp++;
      if (obs() !== expv(k, 0, k == 10)) begin
        n_bad++;
        $display("FAIL sync stop=%0d edge %0d: got %h, want %h", with_stop, k, obs(), expv(k, 0, k == 10));
      end
    end
  endtask

  task automatic test_stall;
    // Enters with CNT=15; bring phase to 10 first.
    for (int k = 0; k < 15; k++) step();
    STOP = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      n_cmp++;
      if (SCAFAL !== (k >= 64) || CNT !== 5'd10) begin
        n_bad++;
        $display("FAIL stall edge %0d: scafal %b cnt %0d, want scafal %b cnt 10", k, SCAFAL, CNT, (k >= 64));
      end
    end
    STOP = 1'b0;
    step();
    n_cmp++;
    if (SCAFAL !== 1'b1 || CNT !== 5'd11) begin
      n_bad++;
      $display("FAIL stall sticky: scafal %b cnt %0d, want 1 cnt 11", SCAFAL, CNT);
    end
    CLRAL = 1'b1;
    step();
    CLRAL = 1'b0;
    n_cmp++;
    if (SCAFAL !== 1'b0) begin
      n_bad++;
      $display("FAIL stall clear: scafal %b, want 0", SCAFAL);
    end
    STOP = 1'b1;
    for (int k = 1; k <= 63; k++) step();
    n_cmp++;
    if (SCAFAL !== 1'b0) begin
      n_bad++;
      $display("FAIL stall edge63: scafal %b, want 0", SCAFAL);
    end
    CLRAL = 1'b1;
    step();
    CLRAL = 1'b0;
    n_cmp++;
    if (SCAFAL !== 1'b1) begin
      n_bad++;
      $display("FAIL stall set_wins: scafal %b, want 1", SCAFAL);
    end
    STOP = 1'b0;
    step();
    n_cmp++;
    if (SCAFAL !== 1'b1 || CNT !== 5'd13) begin
      n_bad++;
      $display("FAIL stall pre_reset: scafal %b cnt %0d, want 1 cnt 13", SCAFAL, CNT);
    end
  endtask

  task automatic test_async_reset;
    #2;
    rst_ = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== expv(0, 0, 0) || SCAFAL !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %h scafal %b, want %h scafal 0", obs(), SCAFAL, expv(0, 0, 0));
    end
    @(negedge CLOCK);
    rst_ = 1'b1;
    step();
    n_cmp++;
    if (obs() !== expv(1, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_release: got %h, want %h", obs(), expv(1, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stop_low();
    test_stop_high();
    test_sync(1'b0);
    test_sync(1'b1);
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
